instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the control/datapath pair. Owns the program counter and issues word requests to instruction memory through a req/ready handshake. Presents one registered instruction with its PC to the decode/execute logic and advances the PC on consumption, to PC+4 or to the branch/jump target selected by PCSrc. Tolerates variable-latency instruction memory, including zero-wait-state memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
XLEN, 32, PC, address and instruction width.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high reset.
imem_req  output  1  fetch request, held until accepted.
imem_addr  output  XLEN  word-aligned fetch address; equals pc.
imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle.
imem_rdata  input  XLEN  instruction word, valid when imem_req & imem_ready.
Instr  output  XLEN  registered instruction to the control path and datapath.
instr_valid  output  1  Instr, pc and pc_plus4 are valid.
instr_accept  input  1  downstream consumes the instruction this cycle; ignored unless instr_valid.
PCSrc  input  1  take target; sampled only on a consume.
PCTarget  input  XLEN  branch/jump target; sampled only on a consume.
pc  output  XLEN  PC of Instr.
pc_plus4  output  XLEN  pc + 4, for JAL/JALR link.
misalign  output  1  one-cycle pulse when a taken PCTarget has bits [1:0] != 0.
instr_count  output  32  count of consumed instructions.

Behaviour:
- Reset (sync, high): pc=RESET_PC, Instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, misalign=0, instr_count=0, state=BOOT. Reset wins over every other input in the same cycle. Reset during a pending request abandons that request; imem_rdata is not captured.
- States: BOOT, FETCH, HOLD.
- BOOT: imem_req=0. Always goes to FETCH on the next cycle. This gives one clean cycle after reset before the first request.
- FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
  - imem_ready=0: stay in FETCH; imem_addr is held stable.
  - imem_ready=1: Instr<=imem_rdata, instr_valid<=1, go to HOLD.
- HOLD: imem_req=0, instr_valid=1. Instr and pc are stable until a consume.
  - Consume = instr_valid & instr_accept.
  - On consume: pc<=PCSrc ? {PCTarget[XLEN-1:2],2'b00} : pc+4; instr_count<=instr_count+1; instr_valid<=0; go to FETCH.
  - No consume: stay in HOLD.
- Throughput and latency:
  - With zero-wait memory, one instruction every 2 cycles.
  - First instr_valid appears 2 cycles after reset deasserts: BOOT, then FETCH with ready, then valid.
  - Each memory wait cycle adds exactly 1 cycle.
- pc_plus4 = pc + 4, combinational from the pc register. Wraps modulo 2^XLEN: pc=FFFF_FFFC gives pc_plus4=0, and a sequential consume sets pc=0.
- misalign: asserted for exactly the cycle after a consume with PCSrc=1 and PCTarget[1:0]!=0. The PC is still loaded with the target's low bits forced to 00; no trap is raised.
- PCSrc and PCTarget are don't-care when there is no consume. instr_accept while instr_valid=0 has no effect.
- instr_count wraps from FFFF_FFFF to 0.
- imem_ready outside FETCH is ignored.

Decomposition:
- Shared package (riscv_pkg): XLEN, NOP_INSTR=32'h0000_0013, and fetch state encoding (BOOT=2'd0, FETCH=2'd1, HOLD=2'd2).
- One natural sub-module: pc_next_sel. It is combinational: inputs pc, PCSrc, PCTarget; outputs next_pc, pc_plus4, misalign_det. The FSM, registers and counter live in instr_fetch_unit.

Test Plan:
- Reset release, imem_ready tied 1, rdata=addr-tagged words, accept tied 1:
  - first imem_req with addr 0 in cycle 2;
  - instr_valid pulses every 2nd cycle;
  - pc sequence 0,4,8,C;
  - instr_count increments on each consume.
- Wait states, imem_ready low 3 cycles at addr 8: imem_addr holds at 8; instr_valid rises exactly 1 cycle after ready; Instr equals the rdata from the ready cycle.
- Backpressure, instr_accept low 5 cycles in HOLD: Instr, pc and instr_valid stable; no imem_req; instr_count unchanged.
- Branch taken at pc=10 with PCSrc=1, PCTarget=100: next imem_addr=100; pc_plus4 before the consume = 14. Same case with PCSrc=0 gives next addr 14.
- Misaligned target 102 taken: misalign is a single-cycle pulse; next imem_addr=100.
- Reset asserted mid-FETCH with imem_ready=1 the same cycle:
  - rdata is not captured;
  - the next cycle shows pc=RESET_PC, instr_valid=0, Instr=0000_0013, instr_count=0.
- Wrap: force pc=FFFF_FFFC and consume sequentially; pc becomes 0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the fetch stage and its neighbours.
//   XLEN           : PC, address and instruction width
//   NOP_INSTR      : canonical NOP (addi x0, x0, 0) presented after reset
//   fetch_state_t  : fetch FSM state encoding
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// ----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC selection for the fetch stage.
//   pc           : current PC register value
//   PCSrc        : 1 = take PCTarget, 0 = sequential
//   PCTarget     : branch/jump target (low two bits may be non-zero)
//   next_pc      : PC to load on a consume (target is forced word aligned)
//   pc_plus4     : pc + 4, wraps modulo 2^XLEN
//   misalign_det : taken target has non-zero low bits
// ----------------------------------------------------------------------------
module pc_next_sel
    import riscv_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic [XLEN_P-1:0] pc,
    input  logic              PCSrc,
    input  logic [XLEN_P-1:0] PCTarget,
    output logic [XLEN_P-1:0] next_pc,
    output logic [XLEN_P-1:0] pc_plus4,
    output logic              misalign_det
);

    logic [XLEN_P-1:0] w_target_aligned;

    assign pc_plus4         = pc + {{(XLEN_P-3){1'b0}}, 3'd4};
    // Misaligned targets are silently truncated; the pulse is informational.
    assign w_target_aligned = {PCTarget[XLEN_P-1:2], 2'b00};
    assign next_pc          = PCSrc ? w_target_aligned : pc_plus4;
    assign misalign_det     = PCSrc & (PCTarget[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: owns the PC, requests words from instruction memory over a
// req/ready handshake, holds one registered instruction for decode/execute
// and advances the PC when that instruction is consumed.
//   clk, reset        : clock, synchronous active-high reset
//   imem_req/addr     : fetch request and word address (addr == pc)
//   imem_ready/rdata  : memory accept; rdata valid in the same cycle
//   Instr/instr_valid : registered instruction and its valid flag
//   instr_accept      : downstream consume strobe (qualified by instr_valid)
//   PCSrc/PCTarget    : redirect control, sampled only on a consume
//   pc/pc_plus4       : PC of Instr and its sequential successor
//   misalign          : one-cycle pulse after a taken misaligned target
//   instr_count       : number of consumed instructions (wraps)
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN_P   = XLEN
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [XLEN_P-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [XLEN_P-1:0] imem_rdata,
    output logic [XLEN_P-1:0] Instr,
    output logic              instr_valid,
    input  logic              instr_accept,
    input  logic              PCSrc,
    input  logic [XLEN_P-1:0] PCTarget,
    output logic [XLEN_P-1:0] pc,
    output logic [XLEN_P-1:0] pc_plus4,
    output logic              misalign,
    output logic [31:0]       instr_count
);

    fetch_state_t      r_state;
    logic [XLEN_P-1:0] r_pc;
    logic [XLEN_P-1:0] r_instr;
    logic              r_valid;
    logic              r_req;
    logic              r_misalign;
    logic [31:0]       r_count;

    logic [XLEN_P-1:0] w_next_pc;
    logic [XLEN_P-1:0] w_pc_plus4;
    logic              w_misalign_det;
    logic              w_consume;

    pc_next_sel #(
        .XLEN_P (XLEN_P)
    ) u_pc_next_sel (
        .pc           (r_pc),
        .PCSrc        (PCSrc),
        .PCTarget     (PCTarget),
        .next_pc      (w_next_pc),
        .pc_plus4     (w_pc_plus4),
        .misalign_det (w_misalign_det)
    );

    assign w_consume = r_valid & instr_accept;

    // Single-process FSM; req and valid are registered alongside the state so
    // they always match it and never glitch toward memory or decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC[XLEN_P-1:0];
            r_instr    <= NOP_INSTR[XLEN_P-1:0];
            r_valid    <= 1'b0;
            r_req      <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= 32'd0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_req   <= 1'b1;
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_consume) begin
                        r_pc       <= w_next_pc;
                        r_count    <= r_count + 32'd1;
                        r_valid    <= 1'b0;
                        r_req      <= 1'b1;
                        r_misalign <= w_misalign_det;
                        r_state    <= ST_FETCH;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_req   <= 1'b0;
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign Instr       = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign misalign    = r_misalign;
    assign instr_count = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Scoreboard bench: each memory response pushes the expected {pc, instr}
// pair; the pair is popped and compared when the instruction is consumed.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        instr_accept;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] instr_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } sb_t;

    sb_t         sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = tag(imem_addr);

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .Instr        (Instr),
        .instr_valid  (instr_valid),
        .instr_accept (instr_accept),
        .PCSrc        (PCSrc),
        .PCTarget     (PCTarget),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign     (misalign),
        .instr_count  (instr_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release reset and confirm the clean BOOT cycle before the first request.
    task automatic release_reset();
        reset = 1'b0;
        sb.delete();
        exp_pc    = 32'h0;
        exp_count = 32'h0;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
    endtask

    task automatic run_instr(input int waits, input int stalls, input logic take,
                             input logic [31:0] tgt);
        sb_t         item;
        logic        exp_mis;
        int          n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        // Memory wait states; accept while not valid must be ignored.
        for (int w = 0; w < waits; w++) begin
            imem_ready   = 1'b0;
            instr_accept = 1'b1;
            step();
            chk("wait_addr", imem_addr, exp_pc);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_cnt", instr_count, exp_count);
        end
        instr_accept = 1'b0;
        imem_ready   = 1'b1;
        sb.push_back('{pc: exp_pc, ins: tag(exp_pc)});
        step();
        imem_ready = 1'b0;
        chk("valid_rise", {31'd0, instr_valid}, 32'd1);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("mis_clear", {31'd0, misalign}, 32'd0);
        // Backpressure; redirect inputs must be ignored while not consuming.
        for (int s = 0; s < stalls; s++) begin
            PCSrc    = 1'b1;
            PCTarget = $urandom;
            imem_ready = 1'b1;
            step();
            imem_ready = 1'b0;
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", Instr, tag(exp_pc));
            chk("stall_pc", pc, exp_pc);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_cnt", instr_count, exp_count);
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        item = sb.pop_front();
        chk("instr", Instr, item.ins);
        chk("pc", pc, item.pc);
        chk("pc_plus4", pc_plus4, item.pc + 32'd4);
        instr_accept = 1'b1;
        PCSrc        = take;
        PCTarget     = tgt;
        step();
        instr_accept = 1'b0;
        PCSrc        = 1'b0;
        PCTarget     = $urandom;
        exp_count = exp_count + 32'd1;
        exp_mis   = take && (tgt[1:0] != 2'b00);
        chk("count", instr_count, exp_count);
        chk("cons_valid", {31'd0, instr_valid}, 32'd0);
        chk("cons_req", {31'd0, imem_req}, 32'd1);
        chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
        exp_pc = take ? {tgt[31:2], 2'b00} : item.pc + 32'd4;
        chk("next_addr", imem_addr, exp_pc);
        $display("txn pc=%h instr=%h take=%0d tgt=%h next=%h cnt=%0d",
                 item.pc, item.ins, take, tgt, exp_pc, exp_count);
    endtask

    initial begin
        reset        = 1'b1;
        imem_ready   = 1'b0;
        instr_accept = 1'b0;
        PCSrc        = 1'b0;
        PCTarget     = 32'h0;
        exp_pc       = 32'h0;
        exp_count    = 32'h0;
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", Instr, NOP);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        release_reset();

        run_instr(0, 0, 1'b0, 32'h0);             // pc 0
        run_instr(0, 0, 1'b0, 32'h0);             // pc 4
        run_instr(3, 0, 1'b0, 32'h0);             // pc 8, three wait states
        run_instr(0, 5, 1'b0, 32'h0);             // pc C, five stall cycles
        run_instr(0, 0, 1'b1, 32'h0000_0100);     // pc 10 taken to 100
        run_instr(0, 0, 1'b1, 32'h0000_0010);     // back to 10
        run_instr(0, 0, 1'b0, 32'h0000_0100);     // pc 10 not taken -> 14
        run_instr(0, 0, 1'b1, 32'h0000_0102);     // misaligned -> 100
        run_instr(2, 0, 1'b1, 32'hFFFF_FFFC);     // jump to top of space
        run_instr(0, 0, 1'b0, 32'h0);             // FFFF_FFFC wraps to 0
        run_instr(0, 0, 1'b0, 32'h0);             // pc 0

        // Reset during FETCH with ready in the same cycle: rdata is dropped.
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        reset      = 1'b1;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_instr", Instr, NOP);
        chk("mid_rst_cnt", instr_count, 32'd0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        release_reset();
        run_instr(0, 0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
